// File: rtl/shot_builder.sv
// Shot manager: spawns shots on trigger edges, moves live shots up once per frame and
// answers renderer requests round-robin. Optional spawn cooldown: SHOT_BUILDER_COOLDOWN_EN.
module shot_builder #(
  parameter int MAX_SHOTS       = 8,
  parameter int SHOT_Y_START    = 440,
  parameter int SHOT_STEP       = 4,
  parameter int H_LAST          = 640,
  parameter int V_LAST          = 480,
  parameter int COOLDOWN_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fire,
  input  logic [9:0] pos_x,
  input  logic [9:0] vcount,
  input  logic [9:0] hcount,
  input  logic       peticion,
  output logic [9:0] position_y,
  output logic [9:0] position_x,
  output logic [5:0] conta
);

  localparam int IW = (MAX_SHOTS > 1) ? $clog2(MAX_SHOTS) : 1;
  localparam logic [9:0] OFF_SCREEN = 10'h3FF;

  logic [MAX_SHOTS-1:0] r_valid;
  logic [9:0]           r_x [MAX_SHOTS];
  logic [9:0]           r_y [MAX_SHOTS];
  logic                 r_fire_q;
  logic [IW-1:0]        r_rd_ptr;
  logic [9:0]           r_pos_x;
  logic [9:0]           r_pos_y;
  logic [5:0]           r_conta;

  logic                 w_tick;
  logic                 w_rise;
  logic                 w_cool_ok;
  logic                 w_spawn;
  logic                 w_free_found;
  logic [IW-1:0]        w_free_idx;
  logic [MAX_SHOTS-1:0] w_valid_n;
  logic [9:0]           w_x_n [MAX_SHOTS];
  logic [9:0]           w_y_n [MAX_SHOTS];
  logic [5:0]           w_cnt;
  logic                 w_hit;
  logic [IW-1:0]        w_hit_idx;

  assign w_tick  = (hcount == 10'(H_LAST)) && (vcount == 10'(V_LAST));
  assign w_rise  = fire && !r_fire_q;
  assign w_spawn = w_rise && w_cool_ok && w_free_found;

`ifdef SHOT_BUILDER_COOLDOWN_EN
  localparam int CW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  logic [CW-1:0] r_cool;

  assign w_cool_ok = (r_cool == '0);

  // a spawn restarts the lockout even if a tick lands in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cool <= '0;
    end else if (w_spawn) begin
      r_cool <= CW'(COOLDOWN_FRAMES);
    end else if (w_tick && (r_cool != '0)) begin
      r_cool <= r_cool - 1'b1;
    end
  end
`else
  assign w_cool_ok = 1'b1;
`endif

  // lowest free slot, taken from the pre-tick mask
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = 0; i < MAX_SHOTS; i++) begin
      if (!r_valid[i] && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_idx   = IW'(i);
      end
    end
  end

  always_comb begin
    w_valid_n = r_valid;
    w_x_n     = r_x;
    w_y_n     = r_y;
    if (w_tick) begin
      for (int i = 0; i < MAX_SHOTS; i++) begin
        if (r_valid[i]) begin
          if (r_y[i] < 10'(SHOT_STEP)) begin
            w_valid_n[i] = 1'b0;
          end else begin
            w_y_n[i] = r_y[i] - 10'(SHOT_STEP);
          end
        end
      end
    end
    if (w_spawn) begin
      w_valid_n[w_free_idx] = 1'b1;
      w_x_n[w_free_idx]     = pos_x;
      w_y_n[w_free_idx]     = 10'(SHOT_Y_START);
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < MAX_SHOTS; i++) begin
      w_cnt = w_cnt + 6'(w_valid_n[i]);
    end
  end

  // round-robin scan starting after rd_ptr, rd_ptr itself checked last
  always_comb begin
    int j;
    w_hit     = 1'b0;
    w_hit_idx = r_rd_ptr;
    for (int k = 1; k <= MAX_SHOTS; k++) begin
      j = (int'(r_rd_ptr) + k) % MAX_SHOTS;
      if (!w_hit && r_valid[IW'(j)]) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= '0;
      r_fire_q <= 1'b0;
      r_rd_ptr <= IW'(MAX_SHOTS - 1);
      r_pos_x  <= OFF_SCREEN;
      r_pos_y  <= OFF_SCREEN;
      r_conta  <= '0;
      for (int i = 0; i < MAX_SHOTS; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else begin
      r_fire_q <= fire;
      r_valid  <= w_valid_n;
      r_x      <= w_x_n;
      r_y      <= w_y_n;
      r_conta  <= w_cnt;
      if (peticion) begin
        if (w_hit) begin
          r_pos_x  <= r_x[w_hit_idx];
          r_pos_y  <= r_y[w_hit_idx];
          r_rd_ptr <= w_hit_idx;
        end else begin
          r_pos_x <= OFF_SCREEN;
          r_pos_y <= OFF_SCREEN;
        end
      end
    end
  end

  assign position_x = r_pos_x;
  assign position_y = r_pos_y;
  assign conta      = r_conta;

endmodule

// File: tb/tb_shot_builder.sv
// Scoreboard bench for shot_builder: stimulus pushes expected (x, y, conta) records,
// a monitor pops and compares them one cycle after each checked edge.
module tb_shot_builder;

  localparam int H_L = 640;
  localparam int V_L = 480;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       fire = 1'b0;
  logic [9:0] pos_x = '0;
  logic [9:0] vcount = '0;
  logic [9:0] hcount = '0;
  logic       peticion = 1'b0;
  logic [9:0] position_y;
  logic [9:0] position_x;
  logic [5:0] conta;
  logic       mon_en = 1'b0;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [5:0] c;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  shot_builder dut (
    .clk        (clk),
    .reset      (reset),
    .fire       (fire),
    .pos_x      (pos_x),
    .vcount     (vcount),
    .hcount     (hcount),
    .peticion   (peticion),
    .position_y (position_y),
    .position_x (position_x),
    .conta      (conta)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic rst, input logic f, input int px, input logic tk,
                     input logic pt, input logic chk, input int ex, input int ey,
                     input int ec, input string nm);
    exp_t e;
    @(negedge clk);
    reset    = rst;
    fire     = f;
    pos_x    = 10'(px);
    hcount   = tk ? 10'(H_L) : 10'd0;
    vcount   = tk ? 10'(V_L) : 10'd0;
    peticion = pt;
    mon_en   = chk;
    if (chk) begin
      e.x  = 10'(ex);
      e.y  = 10'(ey);
      e.c  = 6'(ec);
      e.nm = nm;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, "");
  endtask

  initial begin : monitor
    exp_t e;
    logic en;
    forever begin
      @(posedge clk);
      en = mon_en;
      #1;
      if (en) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_underflow: response with no expected record");
        end else begin
          e = exp_q.pop_front();
          if (position_x !== e.x || position_y !== e.y || conta !== e.c) begin
            n_fail++;
            $display("FAIL %s: got x=%0d y=%0d conta=%0d, expected x=%0d y=%0d conta=%0d",
                     e.nm, position_x, position_y, conta, e.x, e.y, e.c);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    cyc(1, 0, 0, 0, 0, 1, 1023, 1023, 0, "reset");
    cyc(0, 0, 0, 0, 1, 1, 1023, 1023, 0, "req_empty");
`ifndef SHOT_BUILDER_COOLDOWN_EN
    cyc(0, 1, 200, 0, 0, 1, 1023, 1023, 1, "spawn0");
    idle();
    cyc(0, 1, 200, 0, 0, 1, 1023, 1023, 2, "spawn1");
    idle();
    cyc(0, 1, 300, 0, 0, 1, 1023, 1023, 3, "spawn2");
    cyc(0, 1, 300, 0, 0, 1, 1023, 1023, 3, "hold_fire");
    idle();
    cyc(0, 0, 0, 0, 1, 1, 200, 440, 3, "rr0");
    cyc(0, 0, 0, 0, 1, 1, 200, 440, 3, "rr1");
    cyc(0, 0, 0, 0, 1, 1, 300, 440, 3, "rr2");
    cyc(0, 0, 0, 0, 1, 1, 200, 440, 3, "rr_wrap");
    cyc(0, 0, 0, 0, 0, 1, 200, 440, 3, "hold_out");
    cyc(0, 0, 0, 1, 0, 1, 200, 440, 3, "tick1");
    cyc(0, 0, 0, 0, 1, 1, 200, 436, 3, "req_after_tick");
    for (int i = 0; i < 108; i++) cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, "");
    cyc(0, 0, 0, 0, 1, 1, 300, 4, 3, "y4");
    cyc(0, 0, 0, 1, 0, 1, 300, 4, 3, "tick_y4_to_0");
    cyc(0, 0, 0, 0, 1, 1, 200, 0, 3, "y0");
    // tick frees slots 0..2 while a spawn lands in slot 3; the scan sees old contents
    cyc(0, 1, 50, 1, 1, 1, 200, 0, 1, "tick_spawn_req");
    cyc(0, 0, 0, 0, 1, 1, 50, 440, 1, "spawn_not_moved");
    cyc(0, 1, 60, 0, 0, 1, 50, 440, 2, "reuse_freed");
    cyc(0, 0, 0, 0, 1, 1, 60, 440, 2, "freed_slot0");
    cyc(1, 1, 70, 1, 1, 1, 1023, 1023, 0, "reset_mid");
    cyc(0, 0, 0, 0, 1, 1, 1023, 1023, 0, "req_after_reset");
    for (int i = 0; i < 9; i++) begin
      cyc(0, 1, 10 * (i + 1), 0, 0, 1, 1023, 1023, (i < 8) ? i + 1 : 8, "saturate");
      idle();
    end
    for (int i = 0; i < 9; i++) begin
      cyc(0, 0, 0, 0, 1, 1, 10 * ((i % 8) + 1), 440, 8, "sat_scan");
    end
`else
    cyc(0, 1, 100, 0, 0, 1, 1023, 1023, 1, "cd_spawn");
    idle();
    cyc(0, 1, 110, 0, 0, 1, 1023, 1023, 1, "cd_block");
    idle();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, "");
    cyc(0, 1, 120, 0, 0, 1, 1023, 1023, 1, "cd_3ticks");
    idle();
    cyc(0, 0, 0, 1, 0, 1, 1023, 1023, 1, "cd_4th_tick");
    cyc(0, 1, 130, 0, 0, 1, 1023, 1023, 2, "cd_release");
    idle();
    cyc(0, 0, 0, 0, 1, 1, 100, 424, 2, "cd_req0");
    cyc(0, 0, 0, 0, 1, 1, 130, 440, 2, "cd_req1");
    cyc(0, 1, 140, 0, 0, 1, 130, 440, 2, "cd_block2");
    cyc(1, 0, 0, 0, 0, 1, 1023, 1023, 0, "cd_reset");
    cyc(0, 1, 150, 0, 0, 1, 1023, 1023, 1, "cd_after_reset");
`endif
    @(negedge clk);
    mon_en   = 1'b0;
    peticion = 1'b0;
    fire     = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d records left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
